// File: rtl/instr_decode_pkg.sv
// Shared types and constants for the MIPS ID stage.
// Opcodes, ALU op encodings, pipeline latch bundles and control decode.
package instr_decode_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;
        logic    alu_src;
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        alu_op_e alu_op;
    } ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        ctrl_t       ctrl;
    } id_ex_t;

    function automatic ctrl_t decode_ctrl(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            OP_LW: begin
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
                c.alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALU_ADD;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instr_decode_reg_file.sv
// 2-read / 1-write register file with $0 hardwired to zero.
// Reads see a same-edge WB write (write-first behaviour).
module instr_decode_reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] read_addr1,
    input  logic [REG_ADDR_W-1:0] read_addr2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    input  logic                  write_en,
    input  logic [REG_ADDR_W-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_ok;

    assign wr_ok = write_en && (write_addr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[write_addr] <= write_data;
        end
    end

    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (read_addr1 != '0) begin
            read_data1 = (wr_ok && write_addr == read_addr1) ?
                         write_data : regs[read_addr1];
        end
        if (read_addr2 != '0) begin
            read_data2 = (wr_ok && write_addr == read_addr2) ?
                         write_data : regs[read_addr2];
        end
    end

endmodule

// File: rtl/instr_decode.sv
// MIPS ID stage: IF/ID latch, register file, control decode,
// sign extension and the ID/EX latch.
module instr_decode
    import instr_decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] pc_next,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    output logic [31:0] ex_pc_next,
    output logic [31:0] ex_read_data1,
    output logic [31:0] ex_read_data2,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic [5:0]  ex_funct,
    output logic        ex_reg_dst,
    output logic        ex_alu_src,
    output logic        ex_mem_to_reg,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic [1:0]  ex_alu_op
);

    if_id_t      if_id;
    id_ex_t      id_ex;
    logic [31:0] rd1;
    logic [31:0] rd2;
    ctrl_t       dec_ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id <= '0;
        end else if (flush) begin
            if_id.valid <= 1'b0;
            if_id.instr <= NOP_INSTR;
            if_id.pc    <= '0;
        end else if (!stall) begin
            if_id.valid <= 1'b1;
            if_id.instr <= instruction;
            if_id.pc    <= pc_next;
        end
    end

    instr_decode_reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_REGS   (NUM_REGS)
    ) u_reg_file (
        .clk        (clk),
        .reset      (reset),
        .read_addr1 (if_id.instr[25:21]),
        .read_addr2 (if_id.instr[20:16]),
        .read_data1 (rd1),
        .read_data2 (rd2),
        .write_en   (wb_reg_write),
        .write_addr (wb_write_reg),
        .write_data (wb_write_data)
    );

    assign dec_ctrl = decode_ctrl(if_id.instr[31:26]);

    // Data fields load even on a bubble; only control is forced to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex <= '0;
        end else begin
            id_ex.pc    <= if_id.pc;
            id_ex.rd1   <= rd1;
            id_ex.rd2   <= rd2;
            id_ex.imm   <= {{16{if_id.instr[15]}}, if_id.instr[15:0]};
            id_ex.rt    <= if_id.instr[20:16];
            id_ex.rd    <= if_id.instr[15:11];
            id_ex.funct <= if_id.instr[5:0];
            id_ex.ctrl  <= (stall || !if_id.valid) ? '0 : dec_ctrl;
        end
    end

    assign ex_pc_next    = id_ex.pc;
    assign ex_read_data1 = id_ex.rd1;
    assign ex_read_data2 = id_ex.rd2;
    assign ex_imm        = id_ex.imm;
    assign ex_rt         = id_ex.rt;
    assign ex_rd         = id_ex.rd;
    assign ex_funct      = id_ex.funct;
    assign ex_reg_dst    = id_ex.ctrl.reg_dst;
    assign ex_alu_src    = id_ex.ctrl.alu_src;
    assign ex_mem_to_reg = id_ex.ctrl.mem_to_reg;
    assign ex_reg_write  = id_ex.ctrl.reg_write;
    assign ex_mem_read   = id_ex.ctrl.mem_read;
    assign ex_mem_write  = id_ex.ctrl.mem_write;
    assign ex_branch     = id_ex.ctrl.branch;
    assign ex_alu_op     = id_ex.ctrl.alu_op;

endmodule
